// File: rtl/clk_div_prog.sv
// clk_div_prog: multi-channel programmable clock-enable divider.
// Each channel divides CLKIN by a runtime divisor D (2 .. 2^DIV_W-1).
// The output is high for ceil(D/2) cycles and low for floor(D/2) cycles.
// A new divisor is held in a shadow register until the next period boundary.
// At that boundary it becomes active and LOAD_ACK pulses for one cycle.
// Optional feature macro: CLK_DIV_SYNC_EN adds a SYNC input. A SYNC pulse
// forces every enabled channel to start a new period on the same edge.
module clk_div_prog #(
  parameter int CHANNELS  = 4,
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic                      CLKIN,
  input  logic                      RST,
`ifdef CLK_DIV_SYNC_EN
  input  logic                      SYNC,
`endif
  input  logic [CHANNELS-1:0]       EN,
  input  logic [CHANNELS*DIV_W-1:0] DIV_IN,
  input  logic [CHANNELS-1:0]       LOAD,
  output logic [CHANNELS-1:0]       LOAD_ACK,
  output logic [CHANNELS-1:0]       CLKDV,
  output logic [CHANNELS-1:0]       TICK
);

  logic w_sync;

`ifdef CLK_DIV_SYNC_EN
  assign w_sync = SYNC;
`else
  assign w_sync = 1'b0;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_act;
    logic [DIV_W-1:0] r_shd;
    logic             r_pend;
    logic             r_run;
    logic             r_clkdv;
    logic             r_tick;
    logic             r_ack;

    logic [DIV_W-1:0] w_slice;
    logic             w_loadOk;
    logic             w_lastCnt;
    logic             w_start;
    logic [DIV_W:0]   w_hi;
    logic [DIV_W:0]   w_cntNext;

    assign w_slice   = DIV_IN[g*DIV_W +: DIV_W];
    assign w_loadOk  = LOAD[g] && (w_slice > DIV_W'(1));
    assign w_lastCnt = (r_cnt == (r_act - DIV_W'(1)));
    assign w_start   = EN[g] && (!r_run || w_sync || w_lastCnt);
    assign w_hi      = ({1'b0, r_act} + (DIV_W+1)'(1)) >> 1;
    assign w_cntNext = {1'b0, r_cnt} + (DIV_W+1)'(1);

    // Per-channel counter, divisor hand-over and registered outputs.
    // A request captured on the same edge as a boundary is written after the
    // hand-over, so it waits for the following boundary.
    always_ff @(posedge CLKIN) begin
      if (RST) begin
        r_cnt   <= '0;
        r_act   <= DIV_W'(RESET_DIV);
        r_shd   <= DIV_W'(RESET_DIV);
        r_pend  <= 1'b0;
        r_run   <= 1'b0;
        r_clkdv <= 1'b0;
        r_tick  <= 1'b0;
        r_ack   <= 1'b0;
      end else begin
        if (w_start) begin
          r_cnt   <= '0;
          r_clkdv <= 1'b1;
          r_tick  <= 1'b1;
          r_run   <= 1'b1;
          if (r_pend) begin
            r_act  <= r_shd;
            r_pend <= 1'b0;
            r_ack  <= 1'b1;
          end else begin
            r_ack  <= 1'b0;
          end
        end else if (EN[g]) begin
          r_cnt   <= r_cnt + DIV_W'(1);
          r_clkdv <= (w_cntNext < w_hi);
          r_tick  <= 1'b0;
          r_ack   <= 1'b0;
        end else begin
          r_cnt   <= '0;
          r_clkdv <= 1'b0;
          r_tick  <= 1'b0;
          r_run   <= 1'b0;
          if (r_pend) begin
            r_act  <= r_shd;
            r_pend <= 1'b0;
            r_ack  <= 1'b1;
          end else begin
            r_ack  <= 1'b0;
          end
        end
        if (w_loadOk) begin
          r_shd  <= w_slice;
          r_pend <= 1'b1;
        end
      end
    end

    assign CLKDV[g]    = r_clkdv;
    assign TICK[g]     = r_tick;
    assign LOAD_ACK[g] = r_ack;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: self-checking bench for clk_div_prog.
// It uses a 4-channel, 8-bit configuration with a reset divisor of 2.
// The SYNC scenario runs only when CLK_DIV_SYNC_EN is defined.
module tb_clk_div_prog;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int RD = 2;

  logic            clock;
  logic            reset;
  logic            sync;
  logic [CH-1:0]   en;
  logic [CH*W-1:0] divIn;
  logic [CH-1:0]   load;
  logic [CH-1:0]   loadAck;
  logic [CH-1:0]   clkdv;
  logic [CH-1:0]   tick;

  int checks;
  int errors;

  clk_div_prog #(.CHANNELS(CH), .DIV_W(W), .RESET_DIV(RD)) dut (
    .CLKIN    (clock),
    .RST      (reset),
`ifdef CLK_DIV_SYNC_EN
    .SYNC     (sync),
`endif
    .EN       (en),
    .DIV_IN   (divIn),
    .LOAD     (load),
    .LOAD_ACK (loadAck),
    .CLKDV    (clkdv),
    .TICK     (tick)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: each channel tracks its position inside the current
  // period. The output level is derived as position < ceil(D/2).
  int            mPos  [CH];
  bit            mRun  [CH];
  int            mAct  [CH];
  int            mShd  [CH];
  bit            mPend [CH];
  logic [CH-1:0] mClk, mTick, mAck;

  task automatic modelStep(input logic r, input logic s, input logic [CH-1:0] e,
                           input logic [CH-1:0] l, input logic [CH*W-1:0] d);
    for (int c = 0; c < CH; c++) begin
      int req;
      if (r) begin
        mPos[c] = 0; mRun[c] = 0; mAct[c] = RD; mShd[c] = RD; mPend[c] = 0;
        mClk[c] = 0; mTick[c] = 0; mAck[c] = 0;
        continue;
      end
      if (e[c]) begin
        if (!mRun[c] || s || mPos[c] == mAct[c] - 1) begin
          mPos[c] = 0; mRun[c] = 1; mTick[c] = 1; mAck[c] = mPend[c];
          if (mPend[c]) begin mAct[c] = mShd[c]; mPend[c] = 0; end
        end else begin
          mPos[c] = mPos[c] + 1; mTick[c] = 0; mAck[c] = 0;
        end
        mClk[c] = (mPos[c] < (mAct[c] + 1) / 2);
      end else begin
        mPos[c] = 0; mRun[c] = 0; mClk[c] = 0; mTick[c] = 0; mAck[c] = mPend[c];
        if (mPend[c]) begin mAct[c] = mShd[c]; mPend[c] = 0; end
      end
      req = int'(d[c*W +: W]);
      if (l[c] && req >= 2) begin mShd[c] = req; mPend[c] = 1; end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [CH-1:0] e,
                               input logic [CH-1:0] l, input logic [CH*W-1:0] d);
    reset = r; sync = s; en = e; load = l; divIn = d;
    modelStep(r, s, e, l, d);
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [CH-1:0] expClk,
                             input logic [CH-1:0] expTick, input logic [CH-1:0] expAck);
    checks++;
    if ({clkdv, tick, loadAck} !== {expClk, expTick, expAck}) begin
      errors++;
      $display("[TB] FAIL %s: clk/tick/ack got %b/%b/%b want %b/%b/%b",
               name, clkdv, tick, loadAck, expClk, expTick, expAck);
    end
  endtask

  task automatic checkTick(input string name, input logic [CH-1:0] expTick);
    checks++;
    if (tick !== expTick) begin
      errors++;
      $display("[TB] FAIL %s: tick got %b want %b", name, tick, expTick);
    end
  endtask

  // Drives channel 0 only and expects every other channel to stay quiet.
  task automatic step0(input string name, input logic r, input logic e0,
                       input logic l0, input logic [W-1:0] d0,
                       input logic c0, input logic t0, input logic a0);
    applyStimulus(r, 1'b0, {3'b000, e0}, {3'b000, l0}, {{(CH-1)*W{1'b0}}, d0});
    checkOutput(name, {3'b000, c0}, {3'b000, t0}, {3'b000, a0});
  endtask

  typedef struct {
    logic            rst;
    logic [CH-1:0]   en;
    logic [CH-1:0]   ld;
    logic [CH*W-1:0] div;
    logic [CH-1:0]   expClk;
    logic [CH-1:0]   expTick;
    logic [CH-1:0]   expAck;
  } vec_t;

  vec_t tbl [18];

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; sync = 1'b0; en = '0; load = '0; divIn = '0;

    // Channel 0 at the reset divisor, channel 1 loaded with 5 while idle,
    // then loads of 1 and 0 that must be rejected.
    tbl[0]  = '{1'b1, 4'h0, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 4'h1, 4'h0, 32'h0000_0000, 4'h1, 4'h1, 4'h0};
    tbl[2]  = '{1'b0, 4'h1, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 4'h0};
    tbl[3]  = '{1'b0, 4'h1, 4'h0, 32'h0000_0000, 4'h1, 4'h1, 4'h0};
    tbl[4]  = '{1'b0, 4'h1, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 4'h0};
    tbl[5]  = '{1'b0, 4'h1, 4'h2, 32'h0000_0500, 4'h1, 4'h1, 4'h0};
    tbl[6]  = '{1'b0, 4'h1, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 4'h2};
    tbl[7]  = '{1'b0, 4'h3, 4'h0, 32'h0000_0000, 4'h3, 4'h3, 4'h0};
    tbl[8]  = '{1'b0, 4'h3, 4'h0, 32'h0000_0000, 4'h2, 4'h0, 4'h0};
    tbl[9]  = '{1'b0, 4'h3, 4'h0, 32'h0000_0000, 4'h3, 4'h1, 4'h0};
    tbl[10] = '{1'b0, 4'h3, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 4'h0};
    tbl[11] = '{1'b0, 4'h3, 4'h0, 32'h0000_0000, 4'h1, 4'h1, 4'h0};
    tbl[12] = '{1'b0, 4'h3, 4'h0, 32'h0000_0000, 4'h2, 4'h2, 4'h0};
    tbl[13] = '{1'b0, 4'h3, 4'h0, 32'h0000_0000, 4'h3, 4'h1, 4'h0};
    tbl[14] = '{1'b0, 4'h3, 4'h2, 32'h0000_0100, 4'h2, 4'h0, 4'h0};
    tbl[15] = '{1'b0, 4'h3, 4'h2, 32'h0000_0000, 4'h1, 4'h1, 4'h0};
    tbl[16] = '{1'b0, 4'h3, 4'h0, 32'h0000_0000, 4'h0, 4'h0, 4'h0};
    tbl[17] = '{1'b0, 4'h3, 4'h0, 32'h0000_0000, 4'h3, 4'h3, 4'h0};

    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i].rst, 1'b0, tbl[i].en, tbl[i].ld, tbl[i].div);
      checkOutput($sformatf("table[%0d]", i), tbl[i].expClk, tbl[i].expTick, tbl[i].expAck);
    end

    // Channel 0 at D=4; a load of 7 arrives while CNT=1.
    step0("A.rst",   1, 0, 0, 8'd0, 0, 0, 0);
    step0("A.ld4",   0, 0, 1, 8'd4, 0, 0, 0);
    step0("A.ack4",  0, 0, 0, 8'd0, 0, 0, 1);
    step0("A.st4",   0, 1, 0, 8'd0, 1, 1, 0);
    step0("A.c1",    0, 1, 0, 8'd0, 1, 0, 0);
    step0("A.ld7",   0, 1, 1, 8'd7, 0, 0, 0);
    step0("A.c3",    0, 1, 0, 8'd0, 0, 0, 0);
    step0("A.st7",   0, 1, 0, 8'd0, 1, 1, 1);
    for (int i = 1; i < 7; i++)
      step0($sformatf("A.p7[%0d]", i), 0, 1, 0, 8'd0, logic'(i < 4), 0, 0);
    step0("A.st7b",  0, 1, 0, 8'd0, 1, 1, 0);

    // Two loads before the boundary: the second one wins with a single ack.
    step0("B.ld3",   0, 1, 1, 8'd3, 1, 0, 0);
    step0("B.ld5",   0, 1, 1, 8'd5, 1, 0, 0);
    for (int i = 3; i < 7; i++)
      step0($sformatf("B.p7[%0d]", i), 0, 1, 0, 8'd0, logic'(i < 4), 0, 0);
    step0("B.st5",   0, 1, 0, 8'd0, 1, 1, 1);
    for (int i = 1; i < 5; i++)
      step0($sformatf("B.p5[%0d]", i), 0, 1, 0, 8'd0, logic'(i < 3), 0, 0);
    step0("B.st5b",  0, 1, 0, 8'd0, 1, 1, 0);

    // EN dropped during the high phase, then RST mid-period.
    step0("C.hi",    0, 1, 0, 8'd0, 1, 0, 0);
    step0("C.endrop",0, 0, 0, 8'd0, 0, 0, 0);
    step0("C.rest",  0, 1, 0, 8'd0, 1, 1, 0);
    step0("C.c1",    0, 1, 0, 8'd0, 1, 0, 0);
    step0("C.rst",   1, 1, 0, 8'd0, 0, 0, 0);
    step0("C.d2a",   0, 1, 0, 8'd0, 1, 1, 0);
    step0("C.d2b",   0, 1, 0, 8'd0, 0, 0, 0);
    step0("C.d2c",   0, 1, 0, 8'd0, 1, 1, 0);

`ifdef CLK_DIV_SYNC_EN
    // Channel 0 at D=4 and channel 1 at D=6, started out of phase, then aligned.
    applyStimulus(1, 0, 4'h0, 4'h0, 32'h0);
    applyStimulus(0, 0, 4'h0, 4'h3, 32'h0000_0604);
    applyStimulus(0, 0, 4'h0, 4'h0, 32'h0);
    checkOutput("S.ack", 4'h0, 4'h0, 4'h3);
    applyStimulus(0, 0, 4'h1, 4'h0, 32'h0);
    applyStimulus(0, 0, 4'h3, 4'h0, 32'h0);
    applyStimulus(0, 0, 4'h3, 4'h0, 32'h0);
    applyStimulus(0, 1, 4'h3, 4'h0, 32'h0);
    checkTick("S.sync", 4'h3);
    for (int s = 1; s <= 12; s++) begin
      applyStimulus(0, 0, 4'h3, 4'h0, 32'h0);
      checkTick($sformatf("S.after[%0d]", s), {2'b00, logic'(s % 6 == 0), logic'(s % 4 == 0)});
    end
`endif

    // Random traffic checked cycle by cycle against the model.
    applyStimulus(1, 0, 4'h0, 4'h0, 32'h0);
    checkOutput("R.rst", mClk, mTick, mAck);
    begin
      logic [CH-1:0]   rEn;
      logic [CH-1:0]   rLd;
      logic [CH*W-1:0] rDiv;
      logic            rRst;
      logic            rSync;
      rEn = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        rLd = '0;
        rDiv = '0;
        for (int c = 0; c < CH; c++) begin
          if ($urandom_range(29) == 0) rEn[c] = ~rEn[c];
          if ($urandom_range(15) == 0) rLd[c] = 1'b1;
          case ($urandom_range(15))
            0, 1:    rDiv[c*W +: W] = W'($urandom_range(1));
            2:       rDiv[c*W +: W] = W'($urandom_range(255, 2));
            default: rDiv[c*W +: W] = W'($urandom_range(12, 2));
          endcase
        end
        rRst = ($urandom_range(199) == 0);
        rSync = 1'b0;
`ifdef CLK_DIV_SYNC_EN
        rSync = ($urandom_range(39) == 0);
`endif
        applyStimulus(rRst, rSync, rEn, rLd, rDiv);
        checkOutput($sformatf("R.cyc%0d", cyc), mClk, mTick, mAck);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
